// File: rtl/fetch_prefetch_unit.sv
// Sequential instruction fetch with a credit-limited req/gnt interface and a show-ahead
// prefetch queue; redirects flush the queue and drop responses that were already in flight.
module fetch_prefetch_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     ILEN        = 32,
  parameter int unsigned     INSTR_BYTES = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     QDEPTH      = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_update,
  input  logic [XLEN-1:0] pc_new,
  input  logic            halt,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic [XLEN-1:0] pc
);

  localparam int unsigned     PtrW      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned     CntW      = $clog2(QDEPTH + 1);
  localparam logic [XLEN-1:0] AlignMask = ~XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0] PcStep    = XLEN'(INSTR_BYTES);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   tag_mem [QDEPTH];
  logic [PtrW-1:0]   tag_wr_q, tag_rd_q;
  logic [XLEN-1:0]   q_pc_mem [QDEPTH];
  logic [ILEN-1:0]   q_data_mem [QDEPTH];
  logic [PtrW-1:0]   q_wr_q, q_rd_q;
  logic [CntW-1:0]   q_cnt_q, out_cnt_q, discard_q;
  logic [CntW-1:0]   out_cnt_d;
  logic [CntW:0]     inflight;
  logic              issue, rsp, keep, pop;

  // Queue slots plus in-flight requests never exceed QDEPTH, so the queue cannot overflow.
  always_comb begin
    inflight  = {1'b0, q_cnt_q} + {1'b0, out_cnt_q};
    imem_req  = (state_q == StRun) && !pc_update && (inflight < (CntW + 1)'(QDEPTH));
    issue     = imem_req && imem_gnt;
    rsp       = imem_rvalid && (out_cnt_q != '0);
    keep      = rsp && (discard_q == '0) && !pc_update;
    pop       = instr_valid && instr_ready;
    out_cnt_d = out_cnt_q + CntW'(issue) - CntW'(rsp);
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = (q_cnt_q != '0);
  assign instr       = q_data_mem[q_rd_q];
  assign instr_pc    = q_pc_mem[q_rd_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StBoot;
      pc_q      <= RESET_PC;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      q_wr_q    <= '0;
      q_rd_q    <= '0;
      q_cnt_q   <= '0;
      out_cnt_q <= '0;
      discard_q <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        tag_mem[i]    <= '0;
        q_pc_mem[i]   <= '0;
        q_data_mem[i] <= '0;
      end
    end else begin
      case (state_q)
        StBoot:  state_q <= StRun;
        StRun:   if (halt) state_q <= StHalt;
        StHalt:  if (!halt) state_q <= StRun;
        default: state_q <= StBoot;
      endcase

      if (pc_update) begin
        pc_q <= pc_new & AlignMask;
      end else if (issue) begin
        pc_q <= pc_q + PcStep;
      end

      if (issue) begin
        tag_mem[tag_wr_q] <= pc_q;
        tag_wr_q          <= tag_wr_q + PtrW'(1);
      end
      if (rsp) begin
        tag_rd_q <= tag_rd_q + PtrW'(1);
      end
      out_cnt_q <= out_cnt_d;

      // Everything still in flight after a redirect belongs to the old path.
      if (pc_update) begin
        discard_q <= out_cnt_d;
      end else if (rsp && (discard_q != '0)) begin
        discard_q <= discard_q - CntW'(1);
      end

      if (keep) begin
        q_pc_mem[q_wr_q]   <= tag_mem[tag_rd_q];
        q_data_mem[q_wr_q] <= imem_rdata;
        q_wr_q             <= q_wr_q + PtrW'(1);
      end
      if (pc_update) begin
        q_rd_q  <= q_wr_q;
        q_cnt_q <= '0;
      end else begin
        if (pop) q_rd_q <= q_rd_q + PtrW'(1);
        q_cnt_q <= q_cnt_q + CntW'(keep) - CntW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomised bench for fetch_prefetch_unit: a queue-based reference model and an
// in-order memory model, plus directed scenarios with literal expectations.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_update = 1'b0;
  logic [31:0] pc_new = '0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [31:0] pc;

  fetch_prefetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .pc_update   (pc_update),
    .pc_new      (pc_new),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus knobs
  int unsigned gnt_pct = 100, rdy_pct = 100, spur_pct = 0, lat_lo = 1, lat_hi = 1;
  bit          k_upd = 0, k_halt = 0;
  logic [31:0] k_new = '0;
  int unsigned cyc = 0;

  // Memory model: in-order responses, each with its own due cycle
  typedef struct {logic [31:0] addr; int unsigned due;} mreq_t;
  mreq_t mem_q[$];
  bit    rv_real;

  // Reference model
  typedef enum {MBoot, MRun, MHalt} mstate_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;
  typedef struct {logic [31:0] addr; bit stale;} out_t;
  mstate_t     m_state;
  logic [31:0] m_pc;
  ent_t        m_q[$];
  out_t        m_out[$];

  logic [31:0] issued[$];
  logic [31:0] popped[$];

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction

  function automatic bit m_req();
    return (m_state == MRun) && !pc_update && ((m_q.size() + m_out.size()) < 4);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_state = MBoot;
    m_pc    = '0;
    m_q.delete();
    m_out.delete();
    mem_q.delete();
  endtask

  // Drive inputs on the falling edge and compare the DUT against the model.
  task automatic tick_a();
    bit exp_req;
    @(negedge clk);
    pc_update   = k_upd;
    pc_new      = k_new;
    halt        = k_halt;
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    instr_ready = ($urandom_range(99) < rdy_pct);
    rv_real     = 0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_q.size() > 0) begin
      if (mem_q[0].due <= cyc) begin
        rv_real     = 1;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_q[0].addr);
      end
    end else if ($urandom_range(99) < spur_pct) begin
      imem_rvalid = 1'b1;
    end
    #1;
    exp_req = m_req();
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_q.size() > 0});
    if (m_q.size() > 0) begin
      chk("instr", instr, m_q[0].data);
      chk("instr_pc", instr_pc, m_q[0].pc);
    end
    if (imem_req && imem_gnt) issued.push_back(imem_addr);
    if (instr_valid && instr_ready) popped.push_back(instr_pc);
  endtask

  // Advance the model and the memory at the rising edge.
  task automatic tick_b();
    bit          issue, rsp, pop;
    out_t        o;
    logic [31:0] old_pc;
    @(posedge clk);
    issue  = m_req() && imem_gnt;
    rsp    = imem_rvalid && (m_out.size() > 0);
    pop    = (m_q.size() > 0) && instr_ready;
    old_pc = m_pc;
    if (pop) void'(m_q.pop_front());
    if (rsp) begin
      o = m_out.pop_front();
      if (!o.stale) m_q.push_back('{o.addr, imem_rdata});
    end
    if (pc_update) begin
      m_q.delete();
      foreach (m_out[i]) m_out[i].stale = 1;
      m_pc = pc_new & ~32'd3;
    end else if (issue) begin
      m_out.push_back('{m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    case (m_state)
      MBoot: m_state = MRun;
      MRun:  if (halt) m_state = MHalt;
      MHalt: if (!halt) m_state = MRun;
      default: m_state = MBoot;
    endcase
    if (rv_real) void'(mem_q.pop_front());
    if (issue) mem_q.push_back('{old_pc, cyc + $urandom_range(lat_hi, lat_lo)});
    cyc++;
    k_upd = 0;
  endtask

  task automatic cycle();
    tick_a();
    tick_b();
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_pc", pc, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    model_reset();
    k_upd  = 0;
    k_halt = 0;
    issued.delete();
    popped.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_outstanding(int unsigned n);
    for (int i = 0; i < 20; i++) begin
      if (m_out.size() == n) break;
      cycle();
    end
    chk("outstanding_reached", m_out.size(), n);
  endtask

  initial begin
    int got;
    bit started;
    int n0;
    model_reset();

    // Reset held for two cycles
    #1 reset = 1'b0;
    #1;
    chk("init_pc", pc, 32'd0);
    chk("init_req", {31'd0, imem_req}, 32'd0);
    chk("init_valid", {31'd0, instr_valid}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("init_valid_held", {31'd0, instr_valid}, 32'd0);
    reset = 1'b1;

    // BOOT cycle, then the first request at RESET_PC
    tick_a();
    chk("boot_req", {31'd0, imem_req}, 32'd0);
    tick_b();
    tick_a();
    chk("run_req", {31'd0, imem_req}, 32'd1);
    chk("run_addr", imem_addr, 32'd0);
    tick_b();

    // Streaming with a 1-cycle memory
    got = 0;
    started = 0;
    for (int i = 0; i < 20 && got < 5; i++) begin
      tick_a();
      if (started || instr_valid) begin
        started = 1;
        chk("stream_valid", {31'd0, instr_valid}, 32'd1);
        chk("stream_instr", instr, 32'(got + 1));
        chk("stream_pc", instr_pc, 32'(4 * got));
        got++;
      end
      tick_b();
    end
    chk("stream_count", 32'(got), 32'd5);

    // Backpressure: the credit limit stops issue after four requests
    async_reset();
    rdy_pct = 0;
    repeat (12) cycle();
    chk("bp_issued_n", issued.size(), 32'd4);
    tick_a();
    chk("bp_req_blocked", {31'd0, imem_req}, 32'd0);
    tick_b();
    rdy_pct = 100;
    repeat (10) cycle();
    chk("bp_pops_n", {31'd0, popped.size() >= 4}, 32'd1);
    for (int i = 0; i < 4 && i < popped.size(); i++) chk("bp_pop_pc", popped[i], 32'(4 * i));
    chk("bp_resumed", {31'd0, issued.size() >= 8}, 32'd1);
    for (int i = 0; i < issued.size(); i++) chk("bp_seq", issued[i], 32'(4 * i));

    // Redirect with two requests in flight on a 3-cycle memory
    async_reset();
    lat_lo = 3;
    lat_hi = 3;
    wait_outstanding(2);
    k_upd = 1;
    k_new = 32'd128;
    cycle();
    tick_a();
    chk("redir_empty", {31'd0, instr_valid}, 32'd0);
    tick_b();
    popped.delete();
    repeat (20) cycle();
    chk("redir_count", {31'd0, popped.size() >= 2}, 32'd1);
    if (popped.size() >= 2) begin
      chk("redir_pc0", popped[0], 32'd128);
      chk("redir_pc1", popped[1], 32'd132);
    end

    // Alignment and wrap at the top of the address space
    k_upd = 1;
    k_new = 32'hFFFF_FFFA;
    issued.delete();
    cycle();
    tick_a();
    chk("wrap_pc", pc, 32'hFFFF_FFF8);
    tick_b();
    repeat (15) cycle();
    chk("wrap_issued_n", {31'd0, issued.size() >= 3}, 32'd1);
    if (issued.size() >= 3) begin
      chk("wrap_addr0", issued[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", issued[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", issued[2], 32'h0000_0000);
    end

    // Halt with two in flight: no new issue, buffered work still drains
    async_reset();
    wait_outstanding(2);
    k_halt = 1;
    cycle();
    n0 = issued.size();
    repeat (10) cycle();
    chk("halt_no_issue", issued.size(), 32'(n0));
    chk("halt_drain", popped.size(), 32'(n0));
    tick_a();
    chk("halt_req", {31'd0, imem_req}, 32'd0);
    tick_b();
    k_halt = 0;
    cycle();
    cycle();
    async_reset();
    spur_pct = 100;
    cycle();
    tick_a();
    chk("late_rv_ignored", {31'd0, instr_valid}, 32'd0);
    tick_b();
    spur_pct = 25;

    // Randomised traffic
    gnt_pct = 70;
    rdy_pct = 60;
    lat_lo  = 1;
    lat_hi  = 4;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) < 4) begin
        k_upd = 1;
        k_new = ($urandom_range(1) == 0) ? $urandom : (32'hFFFF_FFE0 | 32'($urandom_range(31)));
      end
      if ($urandom_range(99) < 3) k_halt = ~k_halt;
      cycle();
      if (i == 2000) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised instruction fetch unit that generates sequential PCs, issues requests to instruction memory through a req/gnt handshake with in-order responses, and buffers returned instructions in a prefetch queue. Decode consumes the queue through a valid/ready handshake. Branch redirects (pc_update/pc_new) flush the queue and drop stale in-flight responses. A halt input stops request issue while buffered work drains.

Parameters:
XLEN, 32, address/PC width
ILEN, 32, instruction width
INSTR_BYTES, 4, PC increment; power of 2
RESET_PC, 0, PC loaded on reset
QDEPTH, 4, prefetch queue depth; power of 2, >=2; also the in-flight request limit

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
pc_update  in  1  redirect strobe
pc_new  in  XLEN  redirect target
halt  in  1  suspend request issue
imem_req  out  1  memory request valid
imem_addr  out  XLEN  request address (= pc)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid; responses return in request order
imem_rdata  in  ILEN  response data
instr_valid  out  1  queue head valid
instr  out  ILEN  queue head instruction
instr_pc  out  XLEN  address of queue head
instr_ready  in  1  decode accepts head
pc  out  XLEN  next fetch address

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC, state=BOOT, imem_req=0, instr_valid=0, instr=0, instr_pc=0, queue empty, outstanding=0, discard=0.
- FSM: BOOT -> RUN after one clock with reset=1. RUN -> HALT when halt=1. HALT -> RUN when halt=0. No requests are issued in BOOT or HALT.
- Issue: imem_req=1 in RUN only when pc_update=0 and (queue count + outstanding) < QDEPTH. imem_addr=pc, driven combinationally.
- On req&gnt: pc <= pc+INSTR_BYTES, modulo 2^XLEN (0xFFFFFFFC -> 0). outstanding++. Push pc into the tag FIFO (depth QDEPTH).
- If req=1 and gnt=0, req and addr stay stable until the grant.
- Response handling on rvalid with outstanding>0: pop the tag FIFO and decrement outstanding.
  - If discard>0: drop the data and decrement discard.
  - Otherwise: push {tag, rdata} into the queue.
- rvalid with outstanding=0 is ignored.
- Queue overflow cannot occur because of the credit rule above.
- Output: show-ahead queue. instr_valid = queue non-empty; instr/instr_pc = head. Pop on instr_valid & instr_ready.
- Push and pop in the same cycle are both honoured.
- Latency: response in cycle t appears on instr_valid in cycle t+1.
- Redirect (pc_update=1 in cycle t):
  - imem_req is forced to 0 in cycle t.
  - At the edge: pc <= pc_new with its low log2(INSTR_BYTES) bits cleared, and the queue is flushed.
  - discard <= outstanding after this cycle's response accounting; the tag FIFO is retained so stale entries are popped as their responses arrive.
  - A head handshake completing in cycle t still counts as consumed.
  - New requests may issue from t+1 while stale responses drain.
  - A redirect during HALT updates pc and flushes the queue; the state stays HALT.
- Halt: in-flight responses still enqueue and the output still drains.
- Back-to-back redirects: each later redirect overrides the earlier one; discard is recomputed from current outstanding.
- Asynchronous reset mid-operation clears all state immediately. Responses to pre-reset requests arriving after reset are ignored (outstanding=0).

Test Plan:
1. Hold reset=0 two cycles, then release. Required: pc=0, imem_req=0, instr_valid=0 during reset; BOOT for one cycle; imem_req=1 with imem_addr=0 on the next cycle.
2. Stream with gnt=1, 1-cycle memory returning 1,2,3,4,5 at 0,4,8,12,16, and instr_ready=1. Required: instr 1..5 with instr_pc 0,4,8,12,16 on consecutive cycles, in order.
3. Backpressure with instr_ready=0. Required: exactly 4 requests issued (0,4,8,12), then imem_req=0. Set ready=1: four pops, and requests resume at 16 with no gaps or duplicates.
4. Redirect with 2 responses outstanding, using a 3-cycle memory: pc_update=1 with pc_new=128. Required: queue empties next cycle; the two stale responses are dropped; next instr_pc values are 128, 132.
5. Wrap and alignment: redirect to 0xFFFFFFFA. Required: pc=0xFFFFFFF8; request addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
6. Halt mid-stream with 2 outstanding, then assert reset=0 asynchronously mid-cycle. Required: with halt=1, no new requests are issued while the 2 responses still reach instr. On reset, all outputs return to reset values immediately; a late rvalid is ignored.
